sync_bit_mux: RTL and testbench
===============================

Name: sync_bit_mux

Overview:
- Parameterised N:1 single-bit selector with a registered output.
- A combinational select stage (internal net `mux_out`) picks bit `a[sel]`. A single output register, clocked by `clk` with synchronous active-high reset `rst`, captures that bit and drives `out`.
- Used wherever one bit of a vector must be chosen by index and delivered glitch-free on a clock edge, e.g. upstream of synchroniser stages.

Parameters:
- NUM_INPUTS, 8: number of selectable input bits. Legal range 2..256; any value outside this range is an elaboration error.
- RESET_VAL, 1'b0: value loaded into `out` while `rst` is asserted.
- SEL_W (localparam, not overridable) = $clog2(NUM_INPUTS): width of `sel`.

Ports:
- clk    input   1           rising-edge clock; the only clock in the block.
- rst    input   1           reset; synchronous, active-high.
- a      input   NUM_INPUTS  data vector; bit i is candidate i.
- sel    input   SEL_W       index of the bit to forward.
- out    output  1           registered selected bit.
- sel_err output 1           registered flag: the sampled sel was out of range.

Behaviour:
- Internal net `mux_out` (must keep this exact name so benches can probe it hierarchically):
  - Combinational.
  - mux_out = a[sel] when sel < NUM_INPUTS.
  - mux_out = 1'b0 when sel >= NUM_INPUTS. This case is only possible when NUM_INPUTS is not a power of two.
  - Must be free of X: for any a and sel that contain no X/Z bits, mux_out is never X.
- Out-of-range detect: internal combinational `sel_oor` = (sel >= NUM_INPUTS).
- Register update, on every rising edge of clk:
  - If rst = 1: out <= RESET_VAL; sel_err <= 0.
  - Else: out <= mux_out; sel_err <= sel_oor.
- Latency: exactly 1 cycle from a/sel to out/sel_err. There is no enable; the register loads on every non-reset edge.
- Reset:
  - Synchronous only. Asserting rst between edges has no effect until the next rising edge.
  - Reset has priority over data.
  - Deasserting rst: the first non-reset edge loads mux_out from the a/sel values present at that edge.
  - Reset mid-stream: a single reset edge forces RESET_VAL regardless of a/sel; normal data resumes on the following edge.
- Before the first clock edge, out and sel_err are X. Benches must apply reset before checking.
- Simultaneous change of a and sel: only their values at the sampling edge matter; there is no hold or priority between them.
- Boundaries:
  - sel = 0 selects a[0] (LSB).
  - sel = NUM_INPUTS-1 selects the MSB.
  - For a power-of-two NUM_INPUTS, sel_err is always 0.
- Implementation: synthesisable, no latches, no tristates. The combinational stage is a single always_comb block or equivalent.

Test Plan:
1. Reset: rst=1 for 2 edges with a=8'hFF, sel=3'd7 -> out=0 (RESET_VAL), sel_err=0. Release rst -> next edge gives out=1.
2. Sweep, NUM_INPUTS=8, a=8'b10101010, sel stepped 0..7 one value per cycle:
   - mux_out immediately = 0,1,0,1,0,1,0,1.
   - out follows the same sequence one cycle later.
   - Repeat with a=8'b11001100 -> 0,0,1,1,0,0,1,1.
   - Repeat with a=8'b11110000 -> 0,0,0,0,1,1,1,1.
   - Repeat with a=8'b00001111 -> 1,1,1,1,0,0,0,0.
3. Constant vectors: a=8'hFF for all sel -> out=1 every cycle; a=8'h00 for all sel -> out=0 every cycle; sel_err=0 throughout.
4. Non-power-of-two, NUM_INPUTS=5, a=5'b10110:
   - sel=0..4 -> out=0,1,1,0,1 with sel_err=0.
   - sel=5,6,7 -> out=0, sel_err=1, each one cycle later.
5. Reset mid-operation: during the sweep in scenario 2, assert rst for one edge at sel=3, a=8'b10101010 -> out=0 on that edge. Next edge with sel=5 -> out=1.
6. Same-cycle change: change a from 8'b10101010 to 8'b01010101 and sel from 1 to 2 together, before the edge -> out=1 after the edge (a_new[2]). No intermediate value is captured.

Source files
------------

// File: rtl/sync_bit_mux.sv
// -----------------------------------------------------------------------------
// sync_bit_mux
//
// Parameterised N:1 single-bit selector with a registered output. A
// combinational stage (mux_out) picks a[sel]; one register stage captures it
// on every rising clk edge so the selected bit reaches `out` glitch-free,
// e.g. ahead of a synchroniser chain.
//
// Parameters:
//   NUM_INPUTS : number of selectable bits, legal range 2..256
//   RESET_VAL  : value loaded into `out` while rst is high
//   SEL_W      : width of sel, $clog2(NUM_INPUTS) (not overridable)
//
// Ports:
//   clk     : rising-edge clock, the only clock of the block
//   rst     : synchronous active-high reset, priority over data
//   a       : data vector, bit i is candidate i
//   sel     : index of the bit to forward
//   out     : registered selected bit (1-cycle latency)
//   sel_err : registered flag, the sampled sel was >= NUM_INPUTS
// -----------------------------------------------------------------------------
module sync_bit_mux #(
    parameter int   NUM_INPUTS = 8,
    parameter logic RESET_VAL  = 1'b0,
    localparam int  SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] a,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out,
    output logic                  sel_err
);

    // Refuse to elaborate with an unsupported input count.
    if (NUM_INPUTS < 2 || NUM_INPUTS > 256) begin : g_bad_num_inputs
        $error("sync_bit_mux: NUM_INPUTS must be in 2..256");
    end

    // One extra bit so NUM_INPUTS=256 is representable next to an 8-bit sel.
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_INPUTS);

    logic mux_out;
    logic sel_oor;
    logic out_r;
    logic sel_err_r;

    // Out-of-range detect; constant 0 when NUM_INPUTS is a power of two.
    always_comb begin
        sel_oor = ({1'b0, sel} >= SEL_LIMIT);
    end

    // Select stage: compare against every legal index instead of indexing
    // a[sel] directly, so an out-of-range sel yields 0 rather than X.
    always_comb begin
        mux_out = 1'b0;
        if (sel_oor) begin
            mux_out = 1'b0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (sel == SEL_W'(i)) begin
                    mux_out = a[i];
                end else begin
                    mux_out = mux_out;
                end
            end
        end
    end

    // Output register: reset has priority, otherwise load on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= RESET_VAL;
            sel_err_r <= 1'b0;
        end else begin
            out_r     <= mux_out;
            sel_err_r <= sel_oor;
        end
    end

    assign out     = out_r;
    assign sel_err = sel_err_r;

endmodule

// File: tb/tb_sync_bit_mux.sv
// -----------------------------------------------------------------------------
// tb_sync_bit_mux
//
// Drives two instances together: an 8-input one (RESET_VAL=0) and a 5-input
// one (RESET_VAL=1) whose sel can run past the last input. Expected values
// come from a bit-extraction model: bit = (sel < N) ? (a >> sel) & 1 : 0,
// delayed by one edge, with reset forcing RESET_VAL and clearing sel_err.
// -----------------------------------------------------------------------------
module tb_sync_bit_mux;

    logic       clk;
    logic       rst;
    logic [7:0] a8;
    logic [2:0] sel8;
    logic       out8;
    logic       err8;
    logic [4:0] a5;
    logic [2:0] sel5;
    logic       out5;
    logic       err5;

    int n_checks;
    int n_fail;

    sync_bit_mux #(.NUM_INPUTS(8), .RESET_VAL(1'b0)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .a       (a8),
        .sel     (sel8),
        .out     (out8),
        .sel_err (err8)
    );

    sync_bit_mux #(.NUM_INPUTS(5), .RESET_VAL(1'b1)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .a       (a5),
        .sel     (sel5),
        .out     (out5),
        .sel_err (err5)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: bit `s` of `av` for an n-input selector, 0 when out of range.
    function automatic logic ref_bit(input int unsigned av, input int unsigned s,
                                     input int unsigned n);
        if (s >= n) return 1'b0;
        return 1'((av >> s) & 32'd1);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check the combinational select, then
    // check both registered outputs just after the rising edge.
    task automatic cycle(input logic [7:0] av8, input logic [2:0] s8,
                         input logic [4:0] av5, input logic [2:0] s5,
                         input logic r, input string tag);
        logic e8;
        logic e5;
        a8   = av8;
        sel8 = s8;
        a5   = av5;
        sel5 = s5;
        rst  = r;
        e8 = ref_bit(32'(av8), 32'(s8), 32'd8);
        e5 = ref_bit(32'(av5), 32'(s5), 32'd5);
        #1;
        check({tag, " mux8"}, dut8.mux_out, e8);
        check({tag, " mux5"}, dut5.mux_out, e5);
        @(posedge clk);
        #1;
        check({tag, " out8"}, out8, r ? 1'b0 : e8);
        check({tag, " err8"}, err8, 1'b0);
        check({tag, " out5"}, out5, r ? 1'b1 : e5);
        check({tag, " err5"}, err5, r ? 1'b0 : (32'(s5) >= 32'd5));
    endtask

    logic [7:0] pats [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pats = '{8'b10101010, 8'b11001100, 8'b11110000, 8'b00001111,
                 8'hFF, 8'h00};
        rst  = 1'b1;
        a8   = 8'h00;
        sel8 = 3'd0;
        a5   = 5'd0;
        sel5 = 3'd0;

        // Reset held for two edges with all-ones data, then released.
        cycle(8'hFF, 3'd7, 5'h1F, 3'd4, 1'b1, "reset0");
        cycle(8'hFF, 3'd7, 5'h1F, 3'd4, 1'b1, "reset1");
        cycle(8'hFF, 3'd7, 5'h1F, 3'd4, 1'b0, "release");

        // Directed sweeps, including constant all-ones / all-zeros vectors.
        for (int p = 0; p < 6; p++) begin
            for (int s = 0; s < 8; s++) begin
                cycle(pats[p], 3'(s), pats[p][4:0], 3'(s), 1'b0,
                      $sformatf("sweep p%0d s%0d", p, s));
            end
        end

        // Non-power-of-two instance: in-range and out-of-range selects.
        for (int s = 0; s < 8; s++) begin
            cycle(8'h00, 3'(s), 5'b10110, 3'(s), 1'b0,
                  $sformatf("n5 s%0d", s));
        end

        // Single reset edge in the middle of a sweep.
        for (int s = 0; s < 3; s++) begin
            cycle(8'b10101010, 3'(s), 5'b01010, 3'(s), 1'b0,
                  $sformatf("mid s%0d", s));
        end
        cycle(8'b10101010, 3'd3, 5'b01010, 3'd3, 1'b1, "mid rst");
        cycle(8'b10101010, 3'd5, 5'b01010, 3'd5, 1'b0, "mid resume");

        // a and sel change together before one edge.
        cycle(8'b10101010, 3'd1, 5'b10101, 3'd1, 1'b0, "same old");
        cycle(8'b01010101, 3'd2, 5'b01010, 3'd2, 1'b0, "same new");

        // Random traffic with occasional reset.
        for (int k = 0; k < 300; k++) begin
            cycle(8'($urandom), 3'($urandom_range(7, 0)),
                  5'($urandom), 3'($urandom_range(7, 0)),
                  ($urandom_range(15, 0) == 0),
                  $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
